// File: rtl/mem_arbiter_if.sv
// Bundle of CPU-side (fetch and data ports) and memory-side signals around mem_arbiter.
// Latency: none. This is wiring only.
// Backpressure: carried by I_BUSYWAIT/D_BUSYWAIT toward the CPU and by MEM_BUSYWAIT from memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // instruction fetch port
  logic                  I_READ;
  logic [ADDR_WIDTH-1:0] I_ADDR;
  logic [31:0]           I_RDATA;
  logic                  I_BUSYWAIT;
  // data port
  logic [3:0]            D_READ;
  logic [2:0]            D_WRITE;
  logic [ADDR_WIDTH-1:0] D_ADDR;
  logic [31:0]           D_WDATA;
  logic [31:0]           D_RDATA;
  logic                  D_BUSYWAIT;
  // unified memory port
  logic [3:0]            MEM_READ;
  logic [2:0]            MEM_WRITE;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [31:0]           MEM_WDATA;
  logic [31:0]           MEM_RDATA;
  logic                  MEM_BUSYWAIT;

  // arbiter side
  modport slave (
    input  I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WDATA, MEM_RDATA, MEM_BUSYWAIT,
    output I_RDATA, I_BUSYWAIT, D_RDATA, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
  );

  // environment side: CPU pipeline plus memory
  modport master (
    output I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WDATA, MEM_RDATA, MEM_BUSYWAIT,
    input  I_RDATA, I_BUSYWAIT, D_RDATA, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the IF fetch port and the MA data port (D has priority).
// Latency: 3 cycles per access with a zero-wait memory (IDLE, ACC, DONE); each MEM_BUSYWAIT cycle adds one.
// Backpressure: the requester's busywait stays high until its DONE cycle. Optional macro ARB_FAIR_EN bounds IF starvation.
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_DATA_GRANTS = 4
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, DONE} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  // a fetch is always a full-word load (LW with the enable bit set)
  localparam logic [3:0]            FETCH_CMD = 4'b1010;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};

  // a zero grant limit would let the fairness path starve the data port
  if (MAX_DATA_GRANTS < 1) begin : g_bad_cfg
    $error("mem_arbiter: MAX_DATA_GRANTS must be at least 1");
  end

  state_t                state;
  grant_t                grant;
  logic [3:0]            mem_read_q;
  logic [2:0]            mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [31:0]           i_rdata_q;
  logic [31:0]           d_rdata_q;

  logic d_req;
  logic i_req;
  logic grant_d;
  logic in_done;

  assign d_req   = bus.D_READ[3] | (bus.D_WRITE != 3'd0);
  assign i_req   = bus.I_READ;
  assign in_done = (state == DONE);

`ifdef ARB_FAIR_EN
  localparam int                CNT_W   = $clog2(MAX_DATA_GRANTS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DATA_GRANTS);

  logic [CNT_W-1:0] d_streak;
  logic             force_i;

  // once D has won MAX_DATA_GRANTS times in a row against a waiting IF, IF takes the next slot
  assign force_i = i_req & (d_streak == CNT_MAX);
  assign grant_d = d_req & ~force_i;

  // count consecutive D grants made while IF was also waiting; only IDLE decisions matter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_streak <= '0;
    end else if (state == IDLE) begin
      if (!i_req || !grant_d) begin
        d_streak <= '0;
      end else if (d_streak != CNT_MAX) begin
        d_streak <= d_streak + 1'b1;
      end
    end
  end
`else
  // strict priority: MA is older in the pipeline and must drain first
  assign grant_d = d_req;
`endif

  // arbitration FSM: latch the winner's command in IDLE, hold it until memory completes, then one DONE cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      grant       <= GNT_I;
      mem_read_q  <= '0;
      mem_write_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= D_ACC;
            grant       <= GNT_D;
            mem_read_q  <= bus.D_READ[3] ? bus.D_READ : 4'd0;
            mem_write_q <= bus.D_WRITE;
            mem_addr_q  <= bus.D_ADDR;
            mem_wdata_q <= bus.D_WDATA;
          end else if (i_req) begin
            state       <= I_ACC;
            grant       <= GNT_I;
            mem_read_q  <= FETCH_CMD;
            mem_write_q <= 3'd0;
            mem_addr_q  <= bus.I_ADDR & WORD_MASK;
            mem_wdata_q <= '0;
          end
        end
        I_ACC, D_ACC: begin
          // the access runs to completion even if the requester has already withdrawn
          if (!bus.MEM_BUSYWAIT) begin
            if (mem_read_q[3]) begin
              if (state == I_ACC) begin
                i_rdata_q <= bus.MEM_RDATA;
              end else begin
                d_rdata_q <= bus.MEM_RDATA;
              end
            end
            mem_read_q  <= 4'd0;
            mem_write_q <= 3'd0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.MEM_READ  = mem_read_q;
  assign bus.MEM_WRITE = mem_write_q;
  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WDATA = mem_wdata_q;

  assign bus.I_RDATA   = i_rdata_q;
  assign bus.D_RDATA   = d_rdata_q;

  // busywait drops only in the granted port's DONE cycle and otherwise mirrors the live request
  assign bus.I_BUSYWAIT = i_req & ~(in_done & (grant == GNT_I));
  assign bus.D_BUSYWAIT = d_req & ~(in_done & (grant == GNT_D));

endmodule
